// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage sitting between EX and WB.
// Waits for a variable-latency data response on loads, holds one instruction
// while WB stalls, and selects/extends the loaded byte, halfword, word or
// doubleword. DATA_WIDTH may be 32 or 64.
// Optional forwarding ports are built when MEM_ACCESS_STAGE_FWD_EN is defined.
module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [PC_WIDTH-1:0]       ex_pc,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [REG_ADDR_WIDTH-1:0] ex_dest,
    input  logic                      ex_reg_write,
    input  logic                      ex_is_load,
    input  logic [2:0]                ex_load_type,
    output logic                      mem_allow_in,
    input  logic                      data_resp_valid,
    input  logic [DATA_WIDTH-1:0]     data_resp_data,
    input  logic                      wb_allow_in,
    output logic                      wb_valid,
    output logic [PC_WIDTH-1:0]       wb_pc,
    output logic [DATA_WIDTH-1:0]     wb_result,
    output logic [REG_ADDR_WIDTH-1:0] wb_dest,
    output logic                      wb_reg_write
`ifdef MEM_ACCESS_STAGE_FWD_EN
    ,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_dest,
    output logic                      fwd_data_ready,
    output logic [DATA_WIDTH-1:0]     fwd_data
`endif
);

    localparam int OFF_W = $clog2(DATA_WIDTH / 8);

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LH  = 3'd1;
    localparam logic [2:0] LT_LHU = 3'd2;
    localparam logic [2:0] LT_LB  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;
    localparam logic [2:0] LT_LWU = 3'd5;
    localparam logic [2:0] LT_LD  = 3'd6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        wb_valid_q, wb_valid_d;
    logic [PC_WIDTH-1:0]         pc_q, pc_d;
    logic [DATA_WIDTH-1:0]       result_q, result_d;
    logic [REG_ADDR_WIDTH-1:0]   dest_q, dest_d;
    logic                        reg_write_q, reg_write_d;
    logic [2:0]                  load_type_q, load_type_d;

    logic                        accept;
    logic [OFF_W-1:0]            off;
    logic [OFF_W-1:0]            word_lane;
    logic [7:0]                  byte_val;
    logic [15:0]                 half_val;
    logic [31:0]                 word_val;
    logic [DATA_WIDTH-1:0]       load_value;

    // While a load waits, result_q still holds the effective address, so the lane offset comes from it
    assign off          = result_q[OFF_W-1:0];
    assign word_lane    = off >> 2;
    assign mem_allow_in = (state_q == EMPTY) || ((state_q == DONE) && wb_allow_in);
    assign accept       = mem_allow_in && ex_valid;

    // Lane selection and sign/zero extension of the returned beat
    always_comb begin
        byte_val   = 8'(data_resp_data >> {off, 3'b000});
        half_val   = 16'(data_resp_data >> {off[OFF_W-1:1], 4'b0000});
        word_val   = 32'(data_resp_data >> {word_lane, 5'b00000});
        load_value = DATA_WIDTH'($signed(word_val));
        case (load_type_q)
            LT_LB:   load_value = DATA_WIDTH'($signed(byte_val));
            LT_LBU:  load_value = DATA_WIDTH'(byte_val);
            LT_LH:   load_value = DATA_WIDTH'($signed(half_val));
            LT_LHU:  load_value = DATA_WIDTH'(half_val);
            LT_LWU:  load_value = DATA_WIDTH'(word_val);
            LT_LD:   load_value = data_resp_data;
            LT_LW:   load_value = DATA_WIDTH'($signed(word_val));
            default: load_value = DATA_WIDTH'($signed(word_val));
        endcase
    end

    // Next-state and next-payload selection; a new accept overrides the DONE drain
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        result_d    = result_q;
        dest_d      = dest_q;
        reg_write_d = reg_write_q;
        load_type_d = load_type_q;

        case (state_q)
            WAIT: begin
                if (data_resp_valid) begin
                    state_d  = DONE;
                    result_d = load_value;
                end
            end
            DONE: begin
                if (wb_allow_in && !ex_valid) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (accept) begin
            pc_d        = ex_pc;
            result_d    = ex_alu_result;
            dest_d      = ex_dest;
            reg_write_d = ex_reg_write;
            load_type_d = ex_load_type;
            state_d     = ex_is_load ? WAIT : DONE;
        end

        wb_valid_d = (state_d == DONE);
    end

    // State and payload registers; payload is left untouched by reset so it stays stable
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= EMPTY;
            wb_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= wb_valid_d;
            pc_q        <= pc_d;
            result_q    <= result_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            load_type_q <= load_type_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_pc        = pc_q;
    assign wb_result    = result_q;
    assign wb_dest      = dest_q;
    assign wb_reg_write = reg_write_q;

`ifdef MEM_ACCESS_STAGE_FWD_EN
    assign fwd_valid      = ((state_q == WAIT) || (state_q == DONE)) && reg_write_q;
    assign fwd_dest       = dest_q;
    assign fwd_data_ready = (state_q == DONE);
    assign fwd_data       = result_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed test of mem_access_stage with a 32-bit and a
// 64-bit instance. Forwarding ports are checked when MEM_ACCESS_STAGE_FWD_EN is defined.
module tb_mem_access_stage;

   logic clock;
   logic reset;

   // 32-bit instance signals
   logic        exValid, exRegWrite, exIsLoad;
   logic [31:0] exPc, exAluResult;
   logic [4:0]  exDest;
   logic [2:0]  exLoadType;
   logic        memAllowIn;
   logic        respValid;
   logic [31:0] respData;
   logic        wbAllowIn;
   logic        wbValid, wbRegWrite;
   logic [31:0] wbPc, wbResult;
   logic [4:0]  wbDest;

   // 64-bit instance signals
   logic        exValid64, exIsLoad64;
   logic [31:0] exPc64;
   logic [63:0] exAluResult64;
   logic [2:0]  exLoadType64;
   logic        memAllowIn64;
   logic        respValid64;
   logic [63:0] respData64;
   logic        wbValid64, wbRegWrite64;
   logic [31:0] wbPc64;
   logic [63:0] wbResult64;
   logic [4:0]  wbDest64;

`ifdef MEM_ACCESS_STAGE_FWD_EN
   logic        fwdValid, fwdDataReady, fwdValid64, fwdDataReady64;
   logic [4:0]  fwdDest, fwdDest64;
   logic [31:0] fwdData;
   logic [63:0] fwdData64;
`endif

   int assertCount = 0;
   int failCount   = 0;

   mem_access_stage #(.DATA_WIDTH(32), .PC_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
      .clock(clock), .reset(reset),
      .ex_valid(exValid), .ex_pc(exPc), .ex_alu_result(exAluResult), .ex_dest(exDest),
      .ex_reg_write(exRegWrite), .ex_is_load(exIsLoad), .ex_load_type(exLoadType),
      .mem_allow_in(memAllowIn),
      .data_resp_valid(respValid), .data_resp_data(respData),
      .wb_allow_in(wbAllowIn),
      .wb_valid(wbValid), .wb_pc(wbPc), .wb_result(wbResult), .wb_dest(wbDest),
      .wb_reg_write(wbRegWrite)
`ifdef MEM_ACCESS_STAGE_FWD_EN
      ,
      .fwd_valid(fwdValid), .fwd_dest(fwdDest), .fwd_data_ready(fwdDataReady), .fwd_data(fwdData)
`endif
   );

   mem_access_stage #(.DATA_WIDTH(64), .PC_WIDTH(32), .REG_ADDR_WIDTH(5)) dut64 (
      .clock(clock), .reset(reset),
      .ex_valid(exValid64), .ex_pc(exPc64), .ex_alu_result(exAluResult64), .ex_dest(5'd9),
      .ex_reg_write(1'b1), .ex_is_load(exIsLoad64), .ex_load_type(exLoadType64),
      .mem_allow_in(memAllowIn64),
      .data_resp_valid(respValid64), .data_resp_data(respData64),
      .wb_allow_in(1'b1),
      .wb_valid(wbValid64), .wb_pc(wbPc64), .wb_result(wbResult64), .wb_dest(wbDest64),
      .wb_reg_write(wbRegWrite64)
`ifdef MEM_ACCESS_STAGE_FWD_EN
      ,
      .fwd_valid(fwdValid64), .fwd_dest(fwdDest64), .fwd_data_ready(fwdDataReady64), .fwd_data(fwdData64)
`endif
   );

   // Free-running core clock, 10 time units per cycle
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count one comparison and report it when observed differs from expected
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive the EX-side inputs of the 32-bit instance
   task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] alu,
                                input logic [4:0] dest, input logic regWrite, input logic isLoad,
                                input logic [2:0] loadType);
      exValid     = valid;
      exPc        = pc;
      exAluResult = alu;
      exDest      = dest;
      exRegWrite  = regWrite;
      exIsLoad    = isLoad;
      exLoadType  = loadType;
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // One 32-bit load with a response in the cycle right after accept
   task automatic doLoad32(input logic [2:0] loadType, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] expected, input string tag);
      applyStimulus(1'b1, 32'h200, addr, 5'd7, 1'b1, 1'b1, loadType);
      tick();
      exValid   = 1'b0;
      respValid = 1'b1;
      respData  = data;
      tick();
      respValid = 1'b0;
      #1;
      checkOutput(tag, {32'h0, wbResult}, {32'h0, expected});
      tick();
   endtask

   // One 64-bit load with a response in the cycle right after accept
   task automatic doLoad64(input logic [2:0] loadType, input logic [63:0] addr,
                           input logic [63:0] data, input logic [63:0] expected, input string tag);
      exValid64     = 1'b1;
      exPc64        = 32'h300;
      exAluResult64 = addr;
      exIsLoad64    = 1'b1;
      exLoadType64  = loadType;
      tick();
      exValid64   = 1'b0;
      respValid64 = 1'b1;
      respData64  = data;
      tick();
      respValid64 = 1'b0;
      #1;
      checkOutput(tag, wbResult64, expected);
      tick();
   endtask

   // Directed sequence: reset, throughput, latency, extension, stall, abort, 64-bit lanes
   initial begin
      logic [31:0] addVals [3];
      addVals[0] = 32'h11;
      addVals[1] = 32'h22;
      addVals[2] = 32'h33;

      applyStimulus(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
      respValid = 1'b0; respData = 32'h0; wbAllowIn = 1'b1;
      exValid64 = 1'b0; exPc64 = 32'h0; exAluResult64 = 64'h0; exIsLoad64 = 1'b0;
      exLoadType64 = 3'd0; respValid64 = 1'b0; respData64 = 64'h0;

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checkOutput("reset_wb_valid", {63'h0, wbValid}, 64'h0);
      checkOutput("reset_allow_in", {63'h0, memAllowIn}, 64'h1);
      checkOutput("reset_wb_valid64", {63'h0, wbValid64}, 64'h0);

      // Back-to-back non-loads
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h1000 + 32'(4 * i), addVals[i], 5'(i + 1), 1'b1, 1'b0, 3'd0);
         #1;
         checkOutput("b2b_allow_in", {63'h0, memAllowIn}, 64'h1);
         if (i > 0) begin
            checkOutput("b2b_wb_valid", {63'h0, wbValid}, 64'h1);
            checkOutput("b2b_wb_result", {32'h0, wbResult}, {32'h0, addVals[i-1]});
         end
         tick();
      end
      exValid = 1'b0;
      #1;
      checkOutput("b2b_last_valid", {63'h0, wbValid}, 64'h1);
      checkOutput("b2b_last_result", {32'h0, wbResult}, 64'h33);
      checkOutput("b2b_last_pc", {32'h0, wbPc}, 64'h1008);
      checkOutput("b2b_last_dest", {59'h0, wbDest}, 64'h3);
      tick();
      checkOutput("b2b_drain_valid", {63'h0, wbValid}, 64'h0);

      // Variable-latency load: response four cycles after accept
      applyStimulus(1'b1, 32'h2000, 32'h100, 5'd12, 1'b1, 1'b1, 3'd0);
      tick();
      exValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("lw_wait_allow_in", {63'h0, memAllowIn}, 64'h0);
         checkOutput("lw_wait_wb_valid", {63'h0, wbValid}, 64'h0);
`ifdef MEM_ACCESS_STAGE_FWD_EN
         checkOutput("lw_wait_fwd_valid", {63'h0, fwdValid}, 64'h1);
         checkOutput("lw_wait_fwd_ready", {63'h0, fwdDataReady}, 64'h0);
`endif
         tick();
      end
      respValid = 1'b1;
      respData  = 32'hDEADBEEF;
      #1;
      checkOutput("lw_resp_allow_in", {63'h0, memAllowIn}, 64'h0);
      tick();
      respValid = 1'b0;
      #1;
      checkOutput("lw_done_valid", {63'h0, wbValid}, 64'h1);
      checkOutput("lw_done_result", {32'h0, wbResult}, 64'hDEADBEEF);
      checkOutput("lw_done_dest", {59'h0, wbDest}, 64'd12);
`ifdef MEM_ACCESS_STAGE_FWD_EN
      checkOutput("lw_done_fwd_ready", {63'h0, fwdDataReady}, 64'h1);
      checkOutput("lw_done_fwd_data", {32'h0, fwdData}, 64'hDEADBEEF);
      checkOutput("lw_done_fwd_dest", {59'h0, fwdDest}, 64'd12);
`endif
      tick();
      checkOutput("lw_drain_valid", {63'h0, wbValid}, 64'h0);

      // 32-bit lane selection and extension on 0x80FF7F01
      doLoad32(3'd3, 32'h103, 32'h80FF7F01, 32'hFFFFFF80, "lb_off3");
      doLoad32(3'd4, 32'h103, 32'h80FF7F01, 32'h00000080, "lbu_off3");
      doLoad32(3'd3, 32'h100, 32'h80FF7F01, 32'h00000001, "lb_off0");
      doLoad32(3'd1, 32'h102, 32'h80FF7F01, 32'hFFFF80FF, "lh_off2");
      doLoad32(3'd1, 32'h103, 32'h80FF7F01, 32'hFFFF80FF, "lh_off3_lsb_ignored");
      doLoad32(3'd2, 32'h100, 32'h80FF7F01, 32'h00007F01, "lhu_off0");
      doLoad32(3'd5, 32'h100, 32'h80FF7F01, 32'h80FF7F01, "lwu_32");
      doLoad32(3'd6, 32'h100, 32'h80FF7F01, 32'h80FF7F01, "ld_32");
      doLoad32(3'd7, 32'h100, 32'h80FF7F01, 32'h80FF7F01, "code7_32");

      // WB stall: DONE holds, next instruction waits, stray response ignored
      applyStimulus(1'b1, 32'h3000, 32'h5A, 5'd4, 1'b1, 1'b0, 3'd0);
      tick();
      wbAllowIn = 1'b0;
      applyStimulus(1'b1, 32'h3004, 32'h77, 5'd5, 1'b1, 1'b0, 3'd0);
      respValid = 1'b1;
      respData  = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("stall_wb_valid", {63'h0, wbValid}, 64'h1);
         checkOutput("stall_wb_result", {32'h0, wbResult}, 64'h5A);
         checkOutput("stall_wb_pc", {32'h0, wbPc}, 64'h3000);
         checkOutput("stall_allow_in", {63'h0, memAllowIn}, 64'h0);
         tick();
      end
      respValid = 1'b0;
      wbAllowIn = 1'b1;
      #1;
      checkOutput("release_allow_in", {63'h0, memAllowIn}, 64'h1);
      tick();
      exValid = 1'b0;
      #1;
      checkOutput("release_next_result", {32'h0, wbResult}, 64'h77);
      checkOutput("release_next_dest", {59'h0, wbDest}, 64'h5);
      tick();

      // Reset while waiting for a load, then a stray response
      applyStimulus(1'b1, 32'h4000, 32'h140, 5'd3, 1'b1, 1'b1, 3'd0);
      tick();
      exValid = 1'b0;
      reset   = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checkOutput("abort_wb_valid", {63'h0, wbValid}, 64'h0);
      checkOutput("abort_allow_in", {63'h0, memAllowIn}, 64'h1);
      respValid = 1'b1;
      respData  = 32'h12345678;
      tick();
      respValid = 1'b0;
      #1;
      checkOutput("stray_resp_wb_valid", {63'h0, wbValid}, 64'h0);
      tick();
      checkOutput("stray_resp_wb_valid_later", {63'h0, wbValid}, 64'h0);

      // 64-bit datapath lanes
      doLoad64(3'd0, 64'h104, 64'h80000000_00000001, 64'hFFFFFFFF_80000000, "lw_off4_64");
      doLoad64(3'd5, 64'h104, 64'h80000000_00000001, 64'h00000000_80000000, "lwu_off4_64");
      doLoad64(3'd6, 64'h100, 64'h80000000_00000001, 64'h80000000_00000001, "ld_64");
      doLoad64(3'd0, 64'h100, 64'h80000000_00000001, 64'h00000000_00000001, "lw_off0_64");
      doLoad64(3'd1, 64'h106, 64'h80000000_00000001, 64'hFFFFFFFF_FFFF8000, "lh_off6_64");
      doLoad64(3'd4, 64'h107, 64'h80000000_00000001, 64'h00000000_00000080, "lbu_off7_64");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
